// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 4-bit ALU between two requesters.
// Requests are granted round-robin, operands are registered onto the ALU
// port, and the captured 5-bit result is returned on a per-requester
// valid/ready response channel.
module alu_arbiter #(
    parameter int unsigned RR_INIT = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,

    input  logic       req0_valid_i,
    output logic       req0_ready_o,
    input  logic [3:0] req0_a_i,
    input  logic [3:0] req0_b_i,
    input  logic [2:0] req0_op_i,

    input  logic       req1_valid_i,
    output logic       req1_ready_o,
    input  logic [3:0] req1_a_i,
    input  logic [3:0] req1_b_i,
    input  logic [2:0] req1_op_i,

    output logic       rsp0_valid_o,
    input  logic       rsp0_ready_i,
    output logic [4:0] rsp0_result_o,

    output logic       rsp1_valid_o,
    input  logic       rsp1_ready_i,
    output logic [4:0] rsp1_result_o,

    output logic [3:0] alu_a_o,
    output logic [3:0] alu_b_o,
    output logic [2:0] alu_opcode_o,
    input  logic [4:0] alu_result_i,

    output logic       busy_o
);

    // Last-served starts as the opposite of RR_INIT so RR_INIT wins first contention.
    localparam logic LastInit = (RR_INIT == 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    state_e     state_q;
    logic       grant_q;
    logic       last_q;
    logic       busy_q;
    logic       rsp0_valid_q;
    logic       rsp1_valid_q;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [2:0] op_q;
    logic [4:0] result_q;

    logic       grant_d;
    logic       accept;
    logic       rsp_hs;

    // Winner selection: a lone requester always wins; contention goes to the one not served last.
    always_comb begin
        grant_d = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            grant_d = ~last_q;
        end else if (req1_valid_i) begin
            grant_d = 1'b1;
        end
    end

    // Reset suppresses any accept even though ready is combinational.
    assign accept = (state_q == StIdle) && !rst_i && (req0_valid_i || req1_valid_i);
    assign req0_ready_o = accept && !grant_d;
    assign req1_ready_o = accept && grant_d;

    assign rsp_hs = grant_q ? rsp1_ready_i : rsp0_ready_i;

    // Main FSM: accept in idle, capture the ALU result in exec, hold the response until taken.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_q       <= LastInit;
            busy_q       <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            a_q          <= 4'd0;
            b_q          <= 4'd0;
            op_q         <= 3'd0;
            result_q     <= 5'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        grant_q <= grant_d;
                        a_q     <= grant_d ? req1_a_i : req0_a_i;
                        b_q     <= grant_d ? req1_b_i : req0_b_i;
                        op_q    <= grant_d ? req1_op_i : req0_op_i;
                        busy_q  <= 1'b1;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    result_q     <= alu_result_i;
                    rsp0_valid_q <= ~grant_q;
                    rsp1_valid_q <= grant_q;
                    state_q      <= StResp;
                end
                StResp: begin
                    if (rsp_hs) begin
                        last_q       <= grant_q;
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign rsp0_valid_o  = rsp0_valid_q;
    assign rsp1_valid_o  = rsp1_valid_q;
    assign rsp0_result_o = result_q;
    assign rsp1_result_o = result_q;
    assign alu_a_o       = a_q;
    assign alu_b_o       = b_q;
    assign alu_opcode_o  = op_q;
    assign busy_o        = busy_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational 4-bit ALU (A, B, 3-bit opcode, 5-bit result) between two requesters. Requests arrive on valid/ready channels, are granted round-robin, and have their operands registered onto the ALU port. The 5-bit result is captured and returned on a per-requester valid/ready response channel. The block sits between the ALU instance and its two client blocks, and it is the only driver of the ALU inputs.

## Interface
- `RR_INIT`, default 0: requester that wins the first simultaneous contention after reset (0 or 1).
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req0_valid` input 1: requester 0 has an operation pending.
- `req0_ready` output 1: request 0 accepted this cycle.
- `req0_a`, `req0_b` input 4 each: operands from requester 0.
- `req0_op` input 3: ALU opcode from requester 0.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: same as above, for requester 1.
- `rsp0_valid` output 1: result for requester 0 is available.
- `rsp0_ready` input 1: requester 0 accepts the result.
- `rsp0_result` output 5: result for requester 0.
- `rsp1_valid`, `rsp1_ready`, `rsp1_result`: same as above, for requester 1.
- `alu_a`, `alu_b` output 4 each: registered operands to the ALU.
- `alu_opcode` output 3: registered opcode to the ALU.
- `alu_result` input 5: combinational ALU result.
- `busy` output 1: high in every state except IDLE.

## Operation
- **States:** IDLE, EXEC, RESP. Encoding is implementation choice.
- **IDLE:**
  - If no `reqN_valid` is high, stay in IDLE.
  - If exactly one is valid, grant it.
  - If both are valid, grant the requester not served last.
  - `reqN_ready` is combinational: `(state==IDLE) && grant==N && reqN_valid`. At most one ready is high per cycle.
  - On grant, latch `reqN_a`, `reqN_b`, `reqN_op` into the operand registers that drive `alu_a`, `alu_b`, `alu_opcode`. Latch the grant index. Go to EXEC.
- **EXEC** (exactly one cycle):
  - The ALU is settled on the registered operands.
  - Capture `alu_result` into the result register. Go to RESP.
- **RESP:**
  - Assert `rsp{grant}_valid`; the other `rsp_valid` stays low.
  - `rsp0_result` and `rsp1_result` both show the result register. Only the valid one is meaningful.
  - Stay in RESP, holding result and valid stable, until `rsp{grant}_ready` is high.
  - On the handshake cycle: set last-served to grant, then return to IDLE.
  - A new request cannot be accepted in the handshake cycle.
- **Round-robin:**
  - The last-served pointer updates only on response handshake.
  - After reset, last-served is initialised to `!RR_INIT`.
  - A lone requester is granted back-to-back without waiting on the other.
- **Pass-through:** the block never inspects or modifies opcode or result width. All ALU semantics, including wrap of subtraction into 5 bits, belong to the ALU.
- **Input stability:** `reqN_*` inputs may change freely while `reqN_ready` is low. Only values present on the accept cycle are used.
- **Idle ALU port:** `alu_*` outputs hold the last latched operation between requests.

## Timing
- **Reset values:** state IDLE, `busy` 0, `req0_ready`/`req1_ready` 0, `rsp0_valid`/`rsp1_valid` 0, result register 0, `alu_a`/`alu_b`/`alu_opcode` 0, last-served `!RR_INIT`.
- **Latency:** accept at cycle T, `alu_*` update at T+1, `rsp_valid` rises at T+2.
- **Throughput:** minimum 3 cycles per operation. With `rsp_ready` held high, the next accept is at T+3.
- **Reset mid-operation** (EXEC or RESP):
  - The operation is dropped. No response is ever delivered for it.
  - `rsp_valid` is low the cycle after `rst` is sampled high.
  - The pending requester must re-issue.
- **`rst` overrides everything:** `rst` high together with `reqN_valid` causes no accept.
- **`busy`** is registered from state: it is high starting the cycle after accept and stays high through the handshake cycle.
- **Back-pressure:** while `rsp_ready` is low, `rspN_result` must not change and no `reqN_ready` may assert.

## Test plan
- **Single op:** `req0_valid` with A=7, B=9, op=000, `rsp0_ready`=1.
  - `req0_ready` is high at T.
  - `rsp0_valid` is high at T+2 with `rsp0_result`=16.
  - `rsp1_valid` never asserts.
- **Subtract wrap:** `req1` with A=3, B=5, op=001 → `rsp1_result`=5'b11110 at T+2.
- **Contention:** both requesters valid continuously after reset, `RR_INIT`=0, each with a distinct op.
  - Grants alternate 0,1,0,1.
  - Accepts occur every 3 cycles.
  - Each response carries its own requester's result.
- **Back-pressure:** `rsp0_ready` held low 5 cycles after `rsp0_valid`, with `req1_valid` high throughout.
  - `rsp0_result` stays stable.
  - `req1_ready` stays low until 1 cycle after the `rsp0` handshake.
- **Reset in EXEC:** assert `rst` for 1 cycle at T+1.
  - No `rsp_valid` occurs.
  - All outputs are at reset values.
  - A subsequent request completes normally with the 2-cycle latency.
- **Lone repeat:** `req0` is valid for 3 ops while `req1` is idle → 3 grants to requester 0 at T, T+3, T+6.
